// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and FSM state encoding for the UART FIFO
//                block (oversampling ratio, mid-bit sample point, states).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE = 16;   // ticks per bit time
    localparam int MID_SAMPLE = 8;    // tick within a bit at which RX samples
    localparam int TICK_CNT_W = 4;    // holds 0..OVERSAMPLE-1
    localparam int DIV_CNT_W  = 12;   // holds 0..4094 (CLK_DIV up to 4095)
    localparam int BIT_CNT_W  = 3;    // holds 0..7 (DATA_BITS up to 8)

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync_fifo
//  Description : Show-ahead synchronous FIFO. Pointers carry one extra wrap
//                bit so full and empty are distinguished without a counter.
//                A push into a full FIFO and a pop from an empty one are
//                ignored; the other side of a simultaneous request proceeds.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Status flags, accepted requests and next pointer values
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // Pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care while empty so no reset
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo
//  Description : UART transmitter and receiver with a TX and an RX FIFO,
//                16x oversampling, sticky error flags.
//                Optional feature macro: UART_FIFO_PARITY_EN (adds a parity
//                bit, the PARITY_ODD parameter and the rx_parity_err flag).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 104,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
`ifdef UART_FIFO_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 tx,
    input  logic                 rx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 tx_busy,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
`ifdef UART_FIFO_PARITY_EN
    output logic                 rx_parity_err,
`endif
    input  logic                 err_clr
);

`ifdef UART_FIFO_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
    localparam bit PAR_ODD   = PARITY_ODD;
`else
    localparam bit PARITY_EN = 1'b0;
    localparam bit PAR_ODD   = 1'b0;
`endif

    // ---------------- oversample tick ----------------
    logic [DIV_CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic                 tick;

    // One-cycle tick every CLK_DIV clocks
    always_comb begin
        tick      = (div_cnt_q == DIV_CNT_W'(CLK_DIV - 1));
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_CNT_W'(1);
    end

    // ---------------- TX path ----------------
    logic                  tx_pop, tx_full, tx_empty, tx_load, tx_bit_end;
    logic [DATA_BITS-1:0]  tx_head;
    uart_state_e           tx_state_q, tx_state_d;
    logic [TICK_CNT_W-1:0] tx_tcnt_q, tx_tcnt_d;
    logic [BIT_CNT_W-1:0]  tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
    logic                  tx_par_q, tx_par_d;
    logic                  tx_q, tx_d;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst),
        .push(tx_valid), .push_data(tx_data),
        .pop(tx_pop), .pop_data(tx_head),
        .full(tx_full), .empty(tx_empty)
    );

    // TX frame sequencing; the serial line is decoded from the next state
    // so tx is a clean register output
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        tx_load    = 1'b0;
        tx_bit_end = tick && (tx_tcnt_q == TICK_CNT_W'(OVERSAMPLE - 1));
        if (tick && tx_state_q != ST_IDLE) tx_tcnt_d = tx_tcnt_q + TICK_CNT_W'(1);
        case (tx_state_q)
            ST_IDLE:   if (tick && !tx_empty) tx_load = 1'b1;
            ST_START:  if (tx_bit_end) begin
                           tx_state_d = ST_DATA;
                           tx_bit_d   = '0;
                       end
            ST_DATA:   if (tx_bit_end) begin
                           if (tx_bit_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                               tx_state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                           end else begin
                               tx_bit_d   = tx_bit_q + BIT_CNT_W'(1);
                               tx_shift_d = tx_shift_q >> 1;
                           end
                       end
            ST_PARITY: if (tx_bit_end) tx_state_d = ST_STOP;
            ST_STOP:   if (tx_bit_end) begin
                           if (!tx_empty) tx_load = 1'b1;
                           else           tx_state_d = ST_IDLE;
                       end
            default:   tx_state_d = ST_IDLE;
        endcase
        // Back-to-back frames reuse the same load path as a start from idle
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_par_d   = (^tx_head) ^ PAR_ODD;
            tx_tcnt_d  = '0;
            tx_state_d = ST_START;
        end
        case (tx_state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = tx_shift_d[0];
            ST_PARITY: tx_d = tx_par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // ---------------- RX path ----------------
    logic [1:0]            sync_q, sync_d;
    logic                  rx_s, rx_push, rx_full, rx_empty;
    logic                  rx_sample, rx_bit_end;
    logic                  set_frame, set_ovr;
    uart_state_e           rx_state_q, rx_state_d;
    logic [TICK_CNT_W-1:0] rx_tcnt_q, rx_tcnt_d;
    logic [BIT_CNT_W-1:0]  rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
    logic                  rx_armed_q, rx_armed_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
`ifdef UART_FIFO_PARITY_EN
    logic                  set_par;
    logic                  par_err_q, par_err_d;
`endif

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst),
        .push(rx_push), .push_data(rx_shift_q),
        .pop(rx_ready), .pop_data(rx_data),
        .full(rx_full), .empty(rx_empty)
    );

    // RX frame sequencing, mid-bit sampling and sticky flag updates
    always_comb begin
        sync_d     = {sync_q[0], rx};
        rx_s       = sync_q[1];
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_armed_d = rx_armed_q;
        rx_push    = 1'b0;
        set_frame  = 1'b0;
        set_ovr    = 1'b0;
`ifdef UART_FIFO_PARITY_EN
        set_par    = 1'b0;
`endif
        rx_sample  = tick && (rx_tcnt_q == TICK_CNT_W'(MID_SAMPLE - 1));
        rx_bit_end = tick && (rx_tcnt_q == TICK_CNT_W'(OVERSAMPLE - 1));
        if (tick && rx_state_q != ST_IDLE) rx_tcnt_d = rx_tcnt_q + TICK_CNT_W'(1);
        case (rx_state_q)
            // After a framing error the line must return high before re-arming
            ST_IDLE:   if (!rx_armed_q) begin
                           if (rx_s) rx_armed_d = 1'b1;
                       end else if (!rx_s) begin
                           rx_state_d = ST_START;
                           rx_tcnt_d  = '0;
                       end
            ST_START:  if (rx_sample && rx_s) begin
                           rx_state_d = ST_IDLE;
                       end else if (rx_bit_end) begin
                           rx_state_d = ST_DATA;
                           rx_bit_d   = '0;
                       end
            ST_DATA:   begin
                           if (rx_sample) rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                           if (rx_bit_end) begin
                               if (rx_bit_q == BIT_CNT_W'(DATA_BITS - 1))
                                   rx_state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                               else
                                   rx_bit_d = rx_bit_q + BIT_CNT_W'(1);
                           end
                       end
            ST_PARITY: begin
`ifdef UART_FIFO_PARITY_EN
                           if (rx_sample && (rx_s != ((^rx_shift_q) ^ PAR_ODD))) begin
                               set_par    = 1'b1;
                               rx_state_d = ST_IDLE;
                           end else if (rx_bit_end) begin
                               rx_state_d = ST_STOP;
                           end
`else
                           rx_state_d = ST_IDLE;
`endif
                       end
            // Return to idle right after the stop sample so the next start
            // edge is caught exactly, without accumulating phase error
            ST_STOP:   if (rx_sample) begin
                           rx_state_d = ST_IDLE;
                           if (!rx_s) begin
                               set_frame  = 1'b1;
                               rx_armed_d = 1'b0;
                           end else if (rx_full) begin
                               set_ovr = 1'b1;
                           end else begin
                               rx_push = 1'b1;
                           end
                       end
            default:   rx_state_d = ST_IDLE;
        endcase
        frame_err_d = set_frame | (frame_err_q & ~err_clr);
        overrun_d   = set_ovr   | (overrun_q   & ~err_clr);
`ifdef UART_FIFO_PARITY_EN
        par_err_d   = set_par   | (par_err_q   & ~err_clr);
`endif
    end

    // State registers for tick generator, TX, synchroniser and RX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q   <= '0;
            tx_state_q  <= ST_IDLE;
            tx_tcnt_q   <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_par_q    <= 1'b0;
            tx_q        <= 1'b1;
            sync_q      <= 2'b11;
            rx_state_q  <= ST_IDLE;
            rx_tcnt_q   <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_armed_q  <= 1'b1;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_FIFO_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            div_cnt_q   <= div_cnt_d;
            tx_state_q  <= tx_state_d;
            tx_tcnt_q   <= tx_tcnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_par_q    <= tx_par_d;
            tx_q        <= tx_d;
            sync_q      <= sync_d;
            rx_state_q  <= rx_state_d;
            rx_tcnt_q   <= rx_tcnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_armed_q  <= rx_armed_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_FIFO_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign tx           = tx_q;
    assign tx_ready     = !tx_full;
    assign rx_valid     = !rx_empty;
    assign tx_busy      = !tx_empty || (tx_state_q != ST_IDLE);
    assign rx_frame_err = frame_err_q;
    assign rx_overrun   = overrun_q;
`ifdef UART_FIFO_PARITY_EN
    assign rx_parity_err = par_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_fifo
//  Description : Self-checking bench for uart_fifo (CLK_DIV=4, FIFO_DEPTH=2).
//                Expected line waveforms and received bytes come from a
//                frame model and a byte queue kept in the bench.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_fifo;

    localparam int CLK_DIV    = 4;
    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 2;
    localparam int BIT_CLK    = CLK_DIV * 16;
`ifdef UART_FIFO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FRAME_BITS = PAR_EN ? 11 : 10;

    logic       clk, rst;
    logic       tx, rx_line, rx_drv, loop_en;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, rx_ready;
    logic       tx_busy, rx_frame_err, rx_overrun, err_clr;
`ifdef UART_FIFO_PARITY_EN
    logic       rx_parity_err;
`endif

    int   checks;
    int   failures;
    logic exp_bits[$];
    logic [7:0] exp_q[$];

    assign rx_line = loop_en ? tx : rx_drv;

    uart_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .tx(tx), .rx(rx_line),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_busy(tx_busy), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
`ifdef UART_FIFO_PARITY_EN
        .rx_parity_err(rx_parity_err),
`endif
        .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Serial bit sequence of one frame, index 0 first on the line
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        if (PAR_EN) f[9] = ^d;
        return f;
    endfunction

    task automatic add_frame(input logic [7:0] d);
        logic [10:0] f;
        f = frame_bits(d);
        for (int i = 0; i < FRAME_BITS; i++) exp_bits.push_back(f[i]);
    endtask

    task automatic push_byte(input logic [7:0] d);
        int n;
        @(posedge clk); #1;
        tx_data  = d;
        tx_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!tx_ready && n < 5000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 5000) check_val("push_timeout", 0, 1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_tx_low(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (tx !== 1'b0 && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 3000) check_val({tag, "_start_timeout"}, 0, 1);
    endtask

    // Checks the first and last clock of every expected bit, then the idle return
    task automatic check_line(input string tag);
        int nb;
        nb = exp_bits.size();
        wait_tx_low(tag);
        for (int r = 0; r < nb * BIT_CLK; r++) begin
            if (r % BIT_CLK == 0 || r % BIT_CLK == BIT_CLK - 1)
                check_val($sformatf("%s_bit%0d_at%0d", tag, r / BIT_CLK, r % BIT_CLK),
                          32'(tx), 32'(exp_bits[r / BIT_CLK]));
            if (r == nb * BIT_CLK - 1) check_val({tag, "_busy_last"}, 32'(tx_busy), 1);
            @(negedge clk);
        end
        check_val({tag, "_busy_after"}, 32'(tx_busy), 0);
        check_val({tag, "_idle_high"}, 32'(tx), 1);
        exp_bits.delete();
    endtask

    task automatic wait_rx_valid(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!rx_valid && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 3000) check_val({tag, "_rx_timeout"}, 0, 1);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        @(negedge clk);
        check_val({tag, "_valid"}, 32'(rx_valid), 1);
        check_val({tag, "_data"}, 32'(rx_data), 32'(exp));
        @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
    endtask

    // Bit-bangs one frame onto rx with a chosen stop-bit value
    task automatic send_rx(input logic [7:0] d, input logic stop_val);
        logic [10:0] f;
        f = frame_bits(d);
        f[FRAME_BITS-1] = stop_val;
        @(posedge clk); #1;
        for (int i = 0; i < FRAME_BITS; i++) begin
            rx_drv = f[i];
            repeat (BIT_CLK) @(posedge clk);
            #1;
        end
        rx_drv = 1'b1;
    endtask

    task automatic pulse_err_clr();
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int got;
        logic [7:0] d;
        checks = 0; failures = 0;
        rst = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
        err_clr = 1'b0; loop_en = 1'b0; rx_drv = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_tx", 32'(tx), 1);
        check_val("rst_tx_ready", 32'(tx_ready), 1);
        check_val("rst_rx_valid", 32'(rx_valid), 0);
        check_val("rst_tx_busy", 32'(tx_busy), 0);
        check_val("rst_frame_err", 32'(rx_frame_err), 0);
        check_val("rst_overrun", 32'(rx_overrun), 0);
        rst = 1'b0;

        // Single 0x55 frame: alternating bits of exactly BIT_CLK clocks
        add_frame(8'h55);
        fork
            push_byte(8'h55);
            check_line("f55");
        join

        // Three back-to-back frames through a 2-deep TX FIFO
        add_frame(8'hA5); add_frame(8'h00); add_frame(8'hFF);
        fork
            begin push_byte(8'hA5); push_byte(8'h00); push_byte(8'hFF); end
            check_line("f3");
        join

        // Loopback of 0x3C
        loop_en = 1'b1;
        push_byte(8'h3C);
        wait_rx_valid("lb");
        check_val("lb_frame_err", 32'(rx_frame_err), 0);
        check_val("lb_overrun", 32'(rx_overrun), 0);
`ifdef UART_FIFO_PARITY_EN
        check_val("lb_parity_err", 32'(rx_parity_err), 0);
`endif
        pop_expect("lb_pop", 8'h3C);
        repeat (100) @(posedge clk);
        loop_en = 1'b0;
        @(negedge clk);
        check_val("lb_empty_after_pop", 32'(rx_valid), 0);

        // 4-tick glitch must be rejected
        @(posedge clk); #1 rx_drv = 1'b0;
        repeat (4 * CLK_DIV) @(posedge clk);
        #1 rx_drv = 1'b1;
        repeat (1000) @(posedge clk);
        @(negedge clk);
        check_val("glitch_no_byte", 32'(rx_valid), 0);
        check_val("glitch_no_ferr", 32'(rx_frame_err), 0);

        // Bad stop bit: flagged and discarded, then cleared
        send_rx(8'h81, 1'b0);
        repeat (200) @(posedge clk);
        @(negedge clk);
        check_val("ferr_set", 32'(rx_frame_err), 1);
        check_val("ferr_fifo_empty", 32'(rx_valid), 0);
        pulse_err_clr();
        @(negedge clk);
        check_val("ferr_cleared", 32'(rx_frame_err), 0);

        // Receiver re-armed: a good frame arrives intact
        send_rx(8'h5A, 1'b1);
        wait_rx_valid("rearm");
        pop_expect("rearm_pop", 8'h5A);

        // Overrun with a 2-deep RX FIFO
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        send_rx(8'h33, 1'b1);
        repeat (50) @(posedge clk);
        @(negedge clk);
        check_val("ovr_set", 32'(rx_overrun), 1);
        check_val("ovr_no_ferr", 32'(rx_frame_err), 0);
        pop_expect("ovr_pop0", 8'h11);
        pop_expect("ovr_pop1", 8'h22);
        @(negedge clk);
        check_val("ovr_drained", 32'(rx_valid), 0);
        pulse_err_clr();
        @(negedge clk);
        check_val("ovr_cleared", 32'(rx_overrun), 0);

        // Reset in the middle of a data bit, loopback active
        loop_en = 1'b1;
        push_byte(8'hE7);
        wait_tx_low("mid");
        repeat (3 * BIT_CLK) @(negedge clk);
        #1 rst = 1'b1;
        #1 check_val("mid_rst_tx_async", 32'(tx), 1);
        @(negedge clk);
        check_val("mid_rst_tx_ready", 32'(tx_ready), 1);
        check_val("mid_rst_busy", 32'(tx_busy), 0);
        check_val("mid_rst_rx_valid", 32'(rx_valid), 0);
        rst = 1'b0;
        repeat (2000) @(posedge clk);
        @(negedge clk);
        check_val("mid_no_partial", 32'(rx_valid), 0);
        add_frame(8'hC3);
        fork
            push_byte(8'hC3);
            check_line("post_rst");
        join
        wait_rx_valid("post_rst");
        pop_expect("post_rst_pop", 8'hC3);

        // Randomised loopback traffic against an in-order byte queue
        got = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    d = 8'($urandom);
                    push_byte(d);
                    exp_q.push_back(d);
                    repeat ($urandom_range(0, 300)) @(posedge clk);
                end
            end
            begin
                for (int c = 0; c < 30000 && got < 10; c++) begin
                    @(negedge clk);
                    if (rx_valid && rx_ready) begin
                        if (exp_q.size() == 0) check_val("rand_unexpected", 1, 0);
                        else check_val($sformatf("rand_byte%0d", got), 32'(rx_data), 32'(exp_q.pop_front()));
                        got++;
                    end
                    @(posedge clk); #1 rx_ready = 1'($urandom_range(0, 1));
                end
                rx_ready = 1'b0;
            end
        join
        check_val("rand_count", 32'(got), 10);
        check_val("rand_no_overrun", 32'(rx_overrun), 0);
        check_val("rand_no_ferr", 32'(rx_frame_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 SHALL have parameter CLK_DIV, default 104: clk cycles per 16x oversample tick (16 MHz / 104 / 16 ~ 9600 baud); legal range 2..4095.
REQ-002 SHALL have parameter DATA_BITS, default 8: frame data width; legal range 5..8.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: entries per TX and RX FIFO; power of two, 2..256.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 tx  out  1  serial output, idle high.
REQ-007 rx  in  1  serial input, asynchronous to clk.
REQ-008 tx_data  in  DATA_BITS  byte to transmit.
REQ-009 tx_valid / tx_ready  in / out  1  TX push handshake; transfer when both are high.
REQ-010 rx_data  out  DATA_BITS  head of RX FIFO.
REQ-011 rx_valid / rx_ready  out / in  1  RX pop handshake; transfer when both are high.
REQ-012 tx_busy  out  1  TX FIFO non-empty or frame in progress.
REQ-013 rx_frame_err, rx_overrun  out  1 each  sticky error flags.
REQ-014 err_clr  in  1  one-cycle pulse clearing all sticky flags.

Function
REQ-015 Tick generator SHALL pulse for 1 cycle every CLK_DIV clk cycles; 16 ticks make 1 bit time.
REQ-016 Frame SHALL be: start (0), DATA_BITS data bits LSB first, optional parity, 1 stop bit (1).
REQ-017 tx_ready SHALL equal TX FIFO not full; rx_valid SHALL equal RX FIFO not empty; rx_data SHALL be valid whenever rx_valid is high (show-ahead FIFO).
REQ-018 TX FSM states: IDLE, START, DATA, PARITY, STOP. IDLE -> START on the first tick with the FIFO non-empty, popping the head. Each state SHALL last 16 ticks. STOP -> START if the FIFO is non-empty, else IDLE (back-to-back frames, no idle gap).
REQ-019 RX SHALL pass rx through a 2-flop synchroniser before any use.
REQ-020 RX FSM states: IDLE, START, DATA, PARITY, STOP. IDLE -> START on synchronised low. START samples at tick 8; high -> IDLE (glitch reject). Data and stop SHALL be sampled at tick 8 of their 16-tick bit.
REQ-021 Stop sample low SHALL set rx_frame_err and discard the byte; RX SHALL then wait for rx high before re-arming in IDLE.
REQ-022 Valid byte with RX FIFO full SHALL be dropped, set rx_overrun, and leave FIFO contents unchanged.
REQ-023 Simultaneous push and pop SHALL both succeed when the FIFO is neither empty nor full; on full only the pop succeeds, on empty only the push succeeds.
REQ-024 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full = MSBs differ and remaining bits equal.
REQ-025 A flag set event SHALL take priority over err_clr in the same cycle.
REQ-026 Upper bits of tx_data beyond DATA_BITS do not exist; no padding SHALL be transmitted.

Reset
REQ-027 On rst: tx=1, tx_ready=1, rx_valid=0, tx_busy=0, all error flags 0, both FIFOs empty, both FSMs IDLE, tick counter 0, synchroniser flops 1.
REQ-028 rst asserted mid-frame SHALL force tx high asynchronously and abandon the frame; no partial byte SHALL enter the RX FIFO.

Configuration
REQ-029 With macro UART_FIFO_PARITY_EN defined, the PARITY state SHALL be present, parameter PARITY_ODD (default 0) SHALL select odd/even parity, output rx_parity_err (sticky, cleared by err_clr) SHALL exist, and a parity-failed byte SHALL be discarded.
REQ-030 Without UART_FIFO_PARITY_EN, the PARITY state SHALL be skipped in both FSMs and rx_parity_err SHALL be absent.

Structure
REQ-031 Shared package uart_pkg SHALL hold the FSM state encodings and the OVERSAMPLE=16 and MID_SAMPLE=8 constants.
REQ-032 One sub-module, uart_sync_fifo (parameters WIDTH and DEPTH), SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-033 Push 0x55 with CLK_DIV=4 -> tx shows 0,1,0,1,0,1,0,1,0,1, each bit 64 clk, then returns to idle high.
REQ-034 Push 3 bytes 0xA5,0x00,0xFF -> three contiguous frames with no idle gap; tx_busy falls 1 cycle after the last stop bit ends.
REQ-035 Loop tx to rx, send 0x3C -> rx_valid rises with rx_data=0x3C; no error flags set.
REQ-036 rx low pulse of 4 ticks -> no byte received, RX FSM back in IDLE; rx frame 0x81 with stop bit 0 -> rx_frame_err=1, FIFO empty.
REQ-037 FIFO_DEPTH=2, send 3 frames with rx_ready=0 -> first two bytes retained, rx_overrun=1; err_clr -> flag 0.
REQ-038 rst asserted in the middle of DATA of a TX frame -> tx=1 in the same cycle, FIFOs empty; the next push transmits cleanly.
